gx4000_joy_sched: RTL and testbench
===================================

GX4000_JOY_SCHED -- requirements
Module: gx4000_joy_sched

Interface
REQ-001 SHALL have parameter DEB_FRAMES, default 2, meaning consecutive identical frame samples required before a bit change is published (range 1..7).
REQ-002 SHALL have parameter AF_HALF, default 3, meaning autofire half-period in frames (range 1..15).
REQ-003 SHALL have port clk_sys  in  1  system clock; the block uses one clock only.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset, sampled on clk_sys.
REQ-005 SHALL have port gx4000_mode  in  1  block enable; when low, the FSM holds IDLE and both rows read 8'hFF.
REQ-006 SHALL have port vsync  in  1  frame sync, level; its rising edge is the frame tick.
REQ-007 SHALL have ports joy1, joy2  in  7 each  active-high raw pad bits: [0] right, [1] left, [2] down, [3] up, [4] fire1, [5] fire2, [6] fire3.
REQ-008 SHALL have port joy_swap  in  1  exchanges the pad-to-row assignment; sampled only in state CAPTURE.
REQ-009 SHALL have port af_en  in  2  per-row autofire enable on fire1; [0] row 9, [1] row 6.
REQ-010 SHALL have port row_sel  in  4  keyboard row selected by the PPI.
REQ-011 SHALL have port row_data  out  8  active-low matrix byte for row_sel.
REQ-012 SHALL have port frame_ovr  out  1  one-cycle pulse when a frame tick arrives outside IDLE.

Function
REQ-013 SHALL detect the frame tick as vsync high with a registered previous vsync low.
REQ-014 SHALL run FSM IDLE -> CAPTURE -> FILTER -> CLEAN -> PUBLISH -> IDLE, one cycle per state; leaving IDLE requires a frame tick with gx4000_mode high.
REQ-015 CAPTURE: register joy1/joy2, swapped when joy_swap=1, as padA (row 9) and padB (row 6).
REQ-016 FILTER: per bit, increment a 3-bit stable counter when the sample equals the previous sample, saturating at DEB_FRAMES; otherwise load 1; a filtered bit takes the sample value once its counter reaches DEB_FRAMES.
REQ-017 CLEAN: when filtered left and right are both 1, both SHALL be reported 0; the same rule applies to up and down.
REQ-018 Autofire: a 4-bit frame counter advances in PUBLISH, and a phase bit toggles and the counter clears when the count reaches AF_HALF-1; with the af_en bit set, fire1 is reported as filtered fire1 AND phase.
REQ-019 PUBLISH: both output row registers SHALL update in the same cycle, mapped and inverted as [0] up, [1] down, [2] left, [3] right, [4] fire2, [5] fire1, [6] fire3, [7] 1.
REQ-020 row_data SHALL be registered: row9 reg when row_sel=9, row6 reg when row_sel=6, otherwise 8'hFF; latency is 1 cycle from row_sel.
REQ-021 If a row_sel change and PUBLISH coincide, the row_data on the next cycle SHALL reflect the pre-PUBLISH register values; the following cycle reflects the new values.
REQ-022 A frame tick in any non-IDLE state SHALL be dropped and SHALL pulse frame_ovr.
REQ-023 If gx4000_mode falls mid-sequence, the FSM SHALL return to IDLE next cycle, row registers SHALL be set to 8'hFF, and filter state SHALL be retained.

Reset
REQ-024 On reset the block SHALL set: FSM to IDLE, row registers and row_data to 8'hFF, filtered bits and samples to 0, stable counters to 0, autofire counter and phase to 0, frame_ovr to 0, and previous vsync to 1.
REQ-025 Reset asserted mid-sequence SHALL take priority over all other updates in that cycle.

Structure
REQ-026 Package gx4000_joy_pkg SHALL hold the state enum, the pad bit index constants, the CPC row bit constants, and the row numbers 9 and 6.
REQ-027 Debounce SHALL be sub-module gx4000_joy_debounce (7 bits, parameter DEB_FRAMES, step enable input), instantiated once per pad.

Verification
REQ-028 The bench SHALL cover: after reset with joy1=7'h08 held, 2 ticks and row_sel=9 -> row_data=8'hFE; after 1 tick only -> 8'hFF.
REQ-029 The bench SHALL cover: joy_swap=1 with joy2=7'h10 held, 2 ticks and row_sel=9 -> 8'hDF, and row_sel=6 -> 8'hFF.
REQ-030 The bench SHALL cover: joy1=7'h03 (left and right) held for 3 ticks -> row 9 reads 8'hFF; joy1=7'h0C (up and down) held -> 8'hFF.
REQ-031 The bench SHALL cover: af_en=2'b01 with fire1 held and AF_HALF=3 -> row 9 bit5 alternates 0/1 every 3 frames after debounce.
REQ-032 The bench SHALL cover: a second vsync rising edge 2 cycles after a tick -> frame_ovr pulses 1 cycle and the FSM completes the first sequence unaffected.
REQ-033 The bench SHALL cover: gx4000_mode deasserted during FILTER -> next cycle FSM in IDLE, both rows read 8'hFF; reset during CLEAN -> all reset values of REQ-024.

Source files
------------

// File: rtl/gx4000_joy_pkg.sv
// gx4000_joy_pkg
// Shared definitions for the GX4000 joystick scheduler:
//   - state_e      : frame sequencer states
//   - PAD_*        : bit positions in the raw 7-bit pad word
//   - ROW_*        : bit positions in the CPC keyboard-matrix row byte
//   - ROW_NUM_A/B  : matrix rows fed by pad A (row 9) and pad B (row 6)
//   - clean_pad    : suppresses impossible opposing directions
//   - pad_to_row   : maps a pad word onto an active-low row byte
package gx4000_joy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_FILTER  = 3'd2,
      ST_CLEAN   = 3'd3,
      ST_PUBLISH = 3'd4
   } state_e;

   localparam int PAD_W     = 7;
   localparam int PAD_RIGHT = 0;
   localparam int PAD_LEFT  = 1;
   localparam int PAD_DOWN  = 2;
   localparam int PAD_UP    = 3;
   localparam int PAD_FIRE1 = 4;
   localparam int PAD_FIRE2 = 5;
   localparam int PAD_FIRE3 = 6;

   localparam int ROW_UP    = 0;
   localparam int ROW_DOWN  = 1;
   localparam int ROW_LEFT  = 2;
   localparam int ROW_RIGHT = 3;
   localparam int ROW_FIRE2 = 4;
   localparam int ROW_FIRE1 = 5;
   localparam int ROW_FIRE3 = 6;

   localparam logic [3:0] ROW_NUM_A = 4'd9;
   localparam logic [3:0] ROW_NUM_B = 4'd6;

   // Opposite directions held together are reported as neither.
   function automatic logic [PAD_W-1:0] clean_pad(input logic [PAD_W-1:0] p);
      logic [PAD_W-1:0] c;
      c = p;
      if (p[PAD_LEFT] && p[PAD_RIGHT]) begin
         c[PAD_LEFT]  = 1'b0;
         c[PAD_RIGHT] = 1'b0;
      end
      if (p[PAD_UP] && p[PAD_DOWN]) begin
         c[PAD_UP]   = 1'b0;
         c[PAD_DOWN] = 1'b0;
      end
      return c;
   endfunction

   // Bit 7 has no pad source, so it always reads released (1).
   function automatic logic [7:0] pad_to_row(input logic [PAD_W-1:0] p);
      logic [7:0] pressed;
      pressed            = '0;
      pressed[ROW_UP]    = p[PAD_UP];
      pressed[ROW_DOWN]  = p[PAD_DOWN];
      pressed[ROW_LEFT]  = p[PAD_LEFT];
      pressed[ROW_RIGHT] = p[PAD_RIGHT];
      pressed[ROW_FIRE2] = p[PAD_FIRE2];
      pressed[ROW_FIRE1] = p[PAD_FIRE1];
      pressed[ROW_FIRE3] = p[PAD_FIRE3];
      return ~pressed;
   endfunction

endpackage

// File: rtl/gx4000_joy_debounce.sv
// gx4000_joy_debounce
// Per-bit frame debouncer for one 7-bit pad. A bit is published only after
// DEB_FRAMES consecutive identical samples; samples are taken on step_i.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   step_i   : take one frame sample this cycle
//   sample_i : raw pad bits
//   filt_o   : debounced pad bits
module gx4000_joy_debounce
   import gx4000_joy_pkg::*;
#(
   parameter int DEB_FRAMES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             step_i,
   input  logic [PAD_W-1:0] sample_i,
   output logic [PAD_W-1:0] filt_o
);

   localparam logic [2:0] DEB_MAX = 3'(DEB_FRAMES);

   logic [PAD_W-1:0]      prev_q, prev_d;
   logic [PAD_W-1:0]      filt_q, filt_d;
   logic [PAD_W-1:0][2:0] cnt_q, cnt_d;

   always_comb begin
      prev_d = prev_q;
      filt_d = filt_q;
      cnt_d  = cnt_q;
      if (step_i) begin
         prev_d = sample_i;
         for (int i = 0; i < PAD_W; i++) begin
            // A changed sample counts as the first frame of a new run.
            if (sample_i[i] == prev_q[i]) begin
               cnt_d[i] = (cnt_q[i] >= DEB_MAX) ? DEB_MAX : cnt_q[i] + 3'd1;
            end else begin
               cnt_d[i] = 3'd1;
            end
            if (cnt_d[i] == DEB_MAX) begin
               filt_d[i] = sample_i[i];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= '0;
         filt_q <= '0;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/gx4000_joy_sched.sv
// gx4000_joy_sched
// Samples two joypads once per video frame, debounces, cleans opposing
// directions, applies optional autofire and publishes them as CPC keyboard
// matrix rows 9 (pad A) and 6 (pad B).
// Ports:
//   clk_sys     : system clock
//   reset       : synchronous active-high reset
//   gx4000_mode : block enable; low forces IDLE and released rows
//   vsync       : frame sync level, rising edge starts a frame sequence
//   joy1, joy2  : raw active-high pad bits
//   joy_swap    : swap pad-to-row assignment (sampled in CAPTURE)
//   af_en       : autofire enable on fire1, [0] row 9, [1] row 6
//   row_sel     : keyboard row selected by the PPI
//   row_data    : registered active-low matrix byte for row_sel
//   frame_ovr   : pulse when a frame tick arrives while a sequence runs
module gx4000_joy_sched
   import gx4000_joy_pkg::*;
#(
   parameter int DEB_FRAMES = 2,
   parameter int AF_HALF    = 3
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             gx4000_mode,
   input  logic             vsync,
   input  logic [PAD_W-1:0] joy1,
   input  logic [PAD_W-1:0] joy2,
   input  logic             joy_swap,
   input  logic [1:0]       af_en,
   input  logic [3:0]       row_sel,
   output logic [7:0]       row_data,
   output logic             frame_ovr
);

   localparam logic [3:0] AF_LAST = 4'(AF_HALF - 1);

   state_e           state_q, state_d;
   logic             vsync_prev_q;
   logic             tick;
   logic             frame_ovr_q;
   logic             cap_en, step_en, clean_en, pub_en;
   logic [PAD_W-1:0] pad_a_q, pad_b_q;
   logic [PAD_W-1:0] filt_a, filt_b;
   logic [PAD_W-1:0] clean_a_q, clean_b_q;
   logic [PAD_W-1:0] pub_a, pub_b;
   logic [3:0]       af_cnt_q;
   logic             af_phase_q;
   logic [7:0]       row9_q, row6_q;
   logic [7:0]       row_data_q;

   assign tick = vsync & ~vsync_prev_q;

   // State register
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (tick && gx4000_mode) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_FILTER;
         ST_FILTER:  state_d = ST_CLEAN;
         ST_CLEAN:   state_d = ST_PUBLISH;
         ST_PUBLISH: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      if (!gx4000_mode) state_d = ST_IDLE;
   end

   // Output decode: a state only does its work while the block is enabled
   always_comb begin
      cap_en   = (state_q == ST_CAPTURE) && gx4000_mode;
      step_en  = (state_q == ST_FILTER)  && gx4000_mode;
      clean_en = (state_q == ST_CLEAN)   && gx4000_mode;
      pub_en   = (state_q == ST_PUBLISH) && gx4000_mode;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vsync_prev_q <= 1'b1;
         frame_ovr_q  <= 1'b0;
      end else begin
         vsync_prev_q <= vsync;
         frame_ovr_q  <= tick && (state_q != ST_IDLE);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pad_a_q <= '0;
         pad_b_q <= '0;
      end else if (cap_en) begin
         pad_a_q <= joy_swap ? joy2 : joy1;
         pad_b_q <= joy_swap ? joy1 : joy2;
      end
   end

   gx4000_joy_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_a (
      .clk_i    (clk_sys),
      .rst_i    (reset),
      .step_i   (step_en),
      .sample_i (pad_a_q),
      .filt_o   (filt_a)
   );

   gx4000_joy_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_b (
      .clk_i    (clk_sys),
      .rst_i    (reset),
      .step_i   (step_en),
      .sample_i (pad_b_q),
      .filt_o   (filt_b)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clean_a_q <= '0;
         clean_b_q <= '0;
      end else if (clean_en) begin
         clean_a_q <= clean_pad(filt_a);
         clean_b_q <= clean_pad(filt_b);
      end
   end

   // Autofire gates fire1 with the phase held before this PUBLISH advances it.
   always_comb begin
      pub_a            = clean_a_q;
      pub_b            = clean_b_q;
      pub_a[PAD_FIRE1] = clean_a_q[PAD_FIRE1] & (af_phase_q | ~af_en[0]);
      pub_b[PAD_FIRE1] = clean_b_q[PAD_FIRE1] & (af_phase_q | ~af_en[1]);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         af_cnt_q   <= '0;
         af_phase_q <= 1'b0;
      end else if (pub_en) begin
         if (af_cnt_q == AF_LAST) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
         end else begin
            af_cnt_q <= af_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset || !gx4000_mode) begin
         row9_q <= 8'hFF;
         row6_q <= 8'hFF;
      end else if (pub_en) begin
         row9_q <= pad_to_row(pub_a);
         row6_q <= pad_to_row(pub_b);
      end
   end

   // Reads the row registers as they stand before any same-cycle PUBLISH.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         row_data_q <= 8'hFF;
      end else if (row_sel == ROW_NUM_A) begin
         row_data_q <= row9_q;
      end else if (row_sel == ROW_NUM_B) begin
         row_data_q <= row6_q;
      end else begin
         row_data_q <= 8'hFF;
      end
   end

   assign row_data  = row_data_q;
   assign frame_ovr = frame_ovr_q;

endmodule

// File: tb/tb_gx4000_joy_sched.sv
module tb_gx4000_joy_sched;
   import gx4000_joy_pkg::*;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       gx4000_mode;
   logic       vsync;
   logic [6:0] joy1, joy2;
   logic       joy_swap;
   logic [1:0] af_en;
   logic [3:0] row_sel;
   logic [7:0] row_data;
   logic       frame_ovr;

   gx4000_joy_sched #(.DEB_FRAMES(2), .AF_HALF(3)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .gx4000_mode (gx4000_mode),
      .vsync       (vsync),
      .joy1        (joy1),
      .joy2        (joy2),
      .joy_swap    (joy_swap),
      .af_en       (af_en),
      .row_sel     (row_sel),
      .row_data    (row_data),
      .frame_ovr   (frame_ovr)
   );

   always #5 clk_sys = ~clk_sys;

   localparam int P_ROW   = 0;
   localparam int P_OVR   = 1;
   localparam int P_STATE = 2;
   localparam int P_PREV  = 3;
   localparam int P_FILTA = 4;
   localparam int P_CNTA  = 5;
   localparam int P_AFCNT = 6;
   localparam int P_AFPH  = 7;
   localparam int P_ROW9Q = 8;

   typedef struct {
      int          id;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic logic [31:0] probe(input int id);
      case (id)
         P_ROW:   return 32'(row_data);
         P_OVR:   return 32'(frame_ovr);
         P_STATE: return 32'(dut.state_q);
         P_PREV:  return 32'(dut.vsync_prev_q);
         P_FILTA: return 32'(dut.u_deb_a.filt_q);
         P_CNTA:  return 32'(dut.u_deb_a.cnt_q);
         P_AFCNT: return 32'(dut.af_cnt_q);
         P_AFPH:  return 32'(dut.af_phase_q);
         P_ROW9Q: return 32'(dut.row9_q);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: drains every expectation queued since the last falling edge.
   always @(negedge clk_sys) begin
      while (sb.size() > 0) begin
         chk_t        it;
         logic [31:0] act;
         it  = sb.pop_front();
         act = probe(it.id);
         n_chk++;
         if (act !== it.exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", it.name, act, it.exp);
         end
      end
   end

   task automatic expect_val(input int id, input logic [31:0] exp, input string name);
      chk_t it;
      it.id   = id;
      it.exp  = exp;
      it.name = name;
      sb.push_back(it);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(2);
   endtask

   // Returns one cycle after the tick edge, with the FSM in CAPTURE.
   task automatic tick_pulse();
      vsync = 1'b1;
      cyc(1);
      vsync = 1'b0;
   endtask

   task automatic frame();
      tick_pulse();
      cyc(8);
   endtask

   localparam logic [7:0] AF_EXP [12] = '{8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hDF, 8'hDF,
                                          8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hDF, 8'hDF};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      gx4000_mode = 1'b1;
      vsync       = 1'b0;
      joy1        = '0;
      joy2        = '0;
      joy_swap    = 1'b0;
      af_en       = 2'b00;
      row_sel     = 4'd9;
      cyc(3);
      expect_val(P_STATE, 32'(ST_IDLE), "rst_state");
      expect_val(P_ROW,   32'hFF,       "rst_row");
      expect_val(P_OVR,   32'h0,        "rst_ovr");
      expect_val(P_PREV,  32'h1,        "rst_prev");
      reset = 1'b0;
      cyc(3);

      // Debounce: one frame is not enough, two publish the bit.
      joy1 = 7'h08;
      frame();
      expect_val(P_ROW, 32'hFF, "deb_1tick");
      frame();
      expect_val(P_ROW, 32'hFE, "deb_2tick");
      row_sel = 4'd6;
      cyc(1);
      expect_val(P_ROW, 32'hFF, "row6_idle");
      row_sel = 4'd3;
      cyc(1);
      expect_val(P_ROW, 32'hFF, "row_other");

      // Swap routes joy2 to row 9.
      do_reset();
      joy_swap = 1'b1;
      joy1     = 7'h00;
      joy2     = 7'h10;
      row_sel  = 4'd9;
      frame();
      frame();
      expect_val(P_ROW, 32'hDF, "swap_row9");
      row_sel = 4'd6;
      cyc(1);
      expect_val(P_ROW, 32'hFF, "swap_row6");
      joy1 = 7'h08;
      frame();
      frame();
      expect_val(P_ROW, 32'hFE, "swap_row6_up");
      joy_swap = 1'b0;
      joy1     = 7'h00;
      joy2     = 7'h00;

      // Opposing directions cancel.
      do_reset();
      row_sel = 4'd9;
      joy1    = 7'h03;
      joy2    = 7'h44;
      repeat (3) frame();
      expect_val(P_ROW, 32'hFF, "clean_lr");
      joy1 = 7'h0C;
      repeat (3) frame();
      expect_val(P_ROW, 32'hFF, "clean_ud");
      joy1 = 7'h09;
      frame();
      frame();
      expect_val(P_ROW, 32'hF6, "right_up");
      row_sel = 4'd6;
      cyc(1);
      expect_val(P_ROW, 32'hBD, "row6_down_f3");
      joy1 = 7'h00;
      joy2 = 7'h00;

      // Autofire on row 9 fire1.
      do_reset();
      row_sel = 4'd9;
      af_en   = 2'b01;
      joy1    = 7'h10;
      for (int i = 0; i < 12; i++) begin
         frame();
         expect_val(P_ROW, 32'(AF_EXP[i]), $sformatf("af_f%0d", i + 1));
      end
      af_en = 2'b00;
      joy1  = 7'h00;

      // row_sel change in the PUBLISH cycle sees old, then new, values.
      do_reset();
      joy1    = 7'h08;
      row_sel = 4'd6;
      frame();
      tick_pulse();
      cyc(3);
      row_sel = 4'd9;
      cyc(1);
      expect_val(P_ROW, 32'hFF, "pub_coincide_old");
      cyc(1);
      expect_val(P_ROW, 32'hFE, "pub_coincide_new");

      // Overlapping tick: dropped, flagged, first sequence completes.
      do_reset();
      joy1    = 7'h08;
      row_sel = 4'd9;
      frame();
      tick_pulse();
      expect_val(P_OVR, 32'h0, "ovr_idle_tick");
      cyc(1);
      vsync = 1'b1;
      cyc(1);
      expect_val(P_OVR, 32'h1, "ovr_pulse");
      vsync = 1'b0;
      cyc(1);
      expect_val(P_OVR, 32'h0, "ovr_one_cycle");
      cyc(6);
      expect_val(P_ROW, 32'hFE, "ovr_seq_done");

      // Mode drop during FILTER.
      do_reset();
      joy1    = 7'h08;
      row_sel = 4'd9;
      frame();
      frame();
      expect_val(P_ROW, 32'hFE, "mode_pre");
      tick_pulse();
      cyc(1);
      gx4000_mode = 1'b0;
      cyc(1);
      expect_val(P_STATE, 32'(ST_IDLE), "mode_state");
      cyc(1);
      expect_val(P_ROW, 32'hFF, "mode_row9");
      row_sel = 4'd6;
      cyc(1);
      expect_val(P_ROW, 32'hFF, "mode_row6");
      gx4000_mode = 1'b1;
      row_sel     = 4'd9;
      cyc(2);
      frame();
      expect_val(P_ROW, 32'hFE, "mode_filter_kept");

      // Reset during CLEAN.
      do_reset();
      af_en   = 2'b01;
      joy1    = 7'h18;
      row_sel = 4'd9;
      repeat (4) frame();
      expect_val(P_ROW, 32'hDE, "pre_rst_row");
      tick_pulse();
      cyc(2);
      reset = 1'b1;
      cyc(1);
      expect_val(P_STATE, 32'(ST_IDLE), "rclean_state");
      expect_val(P_ROW,   32'hFF,       "rclean_row");
      expect_val(P_ROW9Q, 32'hFF,       "rclean_row9q");
      expect_val(P_OVR,   32'h0,        "rclean_ovr");
      expect_val(P_PREV,  32'h1,        "rclean_prev");
      expect_val(P_FILTA, 32'h0,        "rclean_filt");
      expect_val(P_CNTA,  32'h0,        "rclean_cnt");
      expect_val(P_AFCNT, 32'h0,        "rclean_afcnt");
      expect_val(P_AFPH,  32'h0,        "rclean_afph");
      reset = 1'b0;
      af_en = 2'b00;
      joy1  = 7'h08;
      cyc(2);
      frame();
      expect_val(P_ROW, 32'hFF, "rclean_deb_restart");

      cyc(2);
      if (sb.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
